// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter and instruction register for the fetch side of
// mycpu. It sits beside the control unit `cu`. It drives the instruction
// memory address, latches fetched instructions into IR and advances PC as
// `cu` commands.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   il_in          instruction load request (cu.il_out)
//   ps_in          PC select: 00 hold, 01 inc, 10 branch, 11 jump (cu.ps_out)
//   ra_in          jump target (register A)
//   imem_rdata_in  instruction memory read data
//   imem_ready_in  read data valid for the current imem_addr_out
//   imem_addr_out  fetch address, always equal to PC
//   imem_req_out   fetch request, high while a load is pending
//   ins_out        IR contents (cu.ins_in)
//   pc_out         current PC
//   stall_out      high while waiting on memory
module pc_ir_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INS_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INS_W-1:0]   NOP_INS  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              il_in,
  input  logic [1:0]        ps_in,
  input  logic [ADDR_W-1:0] ra_in,
  input  logic [INS_W-1:0]  imem_rdata_in,
  input  logic              imem_ready_in,
  output logic [ADDR_W-1:0] imem_addr_out,
  output logic              imem_req_out,
  output logic [INS_W-1:0]  ins_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              stall_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [INS_W-1:0]  ir;
  logic [1:0]        pend_ps;
  logic [ADDR_W-1:0] pend_ra;

  logic [1:0]        sel_ps;
  logic [ADDR_W-1:0] sel_ra;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_nxt;

  // In WAIT the command captured when the stall began is used, so cu can
  // change its outputs freely while frozen.
  assign sel_ps = (state == WAIT) ? pend_ps : ps_in;
  assign sel_ra = (state == WAIT) ? pend_ra : ra_in;

  // Branch offset is taken from the instruction executing now (the current
  // IR), never from the word arriving at this edge.
  assign br_off = {{(ADDR_W-6){ir[8]}}, ir[8:6], ir[2:0]};

  always_comb begin
    pc_nxt = pc;
    case (sel_ps)
      2'b00: pc_nxt = pc;
      2'b01: pc_nxt = pc + 1'b1;
      2'b10: pc_nxt = pc + br_off;
      2'b11: pc_nxt = sel_ra;
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ir      <= NOP_INS;
      pend_ps <= 2'b00;
      pend_ra <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (il_in && !imem_ready_in) begin
            // Slow memory: freeze PC/IR and remember what cu asked for.
            state   <= WAIT;
            pend_ps <= ps_in;
            pend_ra <= ra_in;
          end else begin
            pc <= pc_nxt;
            if (il_in) ir <= imem_rdata_in;
          end
        end
        WAIT: begin
          if (imem_ready_in) begin
            ir    <= imem_rdata_in;
            pc    <= pc_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_out     = (state == WAIT);
  assign imem_req_out  = (state == WAIT) | il_in;
  assign imem_addr_out = pc;
  assign pc_out        = pc;
  assign ins_out       = ir;

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        il_in = 1'b0;
  logic [1:0]  ps_in = 2'b00;
  logic [15:0] ra_in = 16'h0000;
  logic [15:0] imem_rdata_in = 16'h0000;
  logic        imem_ready_in = 1'b1;
  logic [15:0] imem_addr_out;
  logic        imem_req_out;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic        stall_out;

  int n_cmp = 0;
  int n_bad = 0;

  pc_ir_unit dut (
    .clk(clk), .rst(rst), .il_in(il_in), .ps_in(ps_in), .ra_in(ra_in),
    .imem_rdata_in(imem_rdata_in), .imem_ready_in(imem_ready_in),
    .imem_addr_out(imem_addr_out), .imem_req_out(imem_req_out),
    .ins_out(ins_out), .pc_out(pc_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer PC/IR plus a "waiting" flag and the command
  // remembered when the wait began.
  int m_pc, m_ir, m_pps, m_pra;
  bit m_wait, m_valid;

  function automatic int target(int pc, int ir, int ps, int ra);
    int off;
    case (ps)
      0: return pc;
      1: return (pc + 1) % 65536;
      2: begin
        off = ((ir >> 6) & 7) * 8 + (ir & 7);
        if (off >= 32) off -= 64;
        return (pc + off + 65536) % 65536;
      end
      default: return ra;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_pc <= 0; m_ir <= 0; m_wait <= 1'b0; m_pps <= 0; m_pra <= 0;
    end else if (m_wait) begin
      if (imem_ready_in) begin
        m_ir   <= int'(imem_rdata_in);
        m_pc   <= target(m_pc, m_ir, m_pps, m_pra);
        m_wait <= 1'b0;
      end
    end else if (il_in && !imem_ready_in) begin
      m_wait <= 1'b1;
      m_pps  <= int'(ps_in);
      m_pra  <= int'(ra_in);
    end else begin
      m_pc <= target(m_pc, m_ir, int'(ps_in), int'(ra_in));
      if (il_in) m_ir <= int'(imem_rdata_in);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_pc",    32'(pc_out),        32'(m_pc));
      check("cyc_addr",  32'(imem_addr_out), 32'(m_pc));
      check("cyc_ins",   32'(ins_out),       32'(m_ir));
      check("cyc_stall", 32'(stall_out),     32'(m_wait));
      check("cyc_req",   32'(imem_req_out),  32'(m_wait | il_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] addr_hold;

  initial begin
    // Reset, then idle
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_ins", 32'(ins_out), 32'h0);
    check("rst_stall", 32'(stall_out), 32'h0);
    check("rst_req", 32'(imem_req_out), 32'h0);

    // Sequential zero-wait fetch
    for (int k = 1; k <= 3; k++) begin
      il_in = 1'b1; ps_in = 2'b01; imem_rdata_in = 16'hA000 + 16'(k);
      #2;
      check("seq_addr", 32'(imem_addr_out), 32'(k - 1));
      tick();
      check("seq_ins", 32'(ins_out), 32'(16'hA000 + 16'(k)));
      check("seq_pc", 32'(pc_out), 32'(k));
    end

    // Load 01C7 while jumping to 0000, then branch -1
    il_in = 1'b1; ps_in = 2'b11; ra_in = 16'h0000; imem_rdata_in = 16'h01C7;
    tick();
    check("ld_ins", 32'(ins_out), 32'h01C7);
    check("ld_pc", 32'(pc_out), 32'h0000);
    il_in = 1'b0; ps_in = 2'b10;
    tick();
    check("br_neg_wrap", 32'(pc_out), 32'hFFFF);

    // +31 from FFF0 wraps to 000F
    il_in = 1'b1; ps_in = 2'b11; ra_in = 16'hFFF0; imem_rdata_in = 16'h00C7;
    tick();
    il_in = 1'b0; ps_in = 2'b10;
    tick();
    check("br_pos_wrap", 32'(pc_out), 32'h000F);

    // Branch with simultaneous load uses the old IR (+31)
    il_in = 1'b1; ps_in = 2'b10; imem_rdata_in = 16'h01C7;
    tick();
    check("br_old_ir_pc", 32'(pc_out), 32'h002E);
    check("br_old_ir_ins", 32'(ins_out), 32'h01C7);

    // Jump
    il_in = 1'b0; ps_in = 2'b11; ra_in = 16'h1234;
    tick();
    check("jmp_pc", 32'(pc_out), 32'h1234);
    check("jmp_ins", 32'(ins_out), 32'h01C7);

    // Wait states: ready low for 3 cycles, cu changes its command meanwhile
    imem_ready_in = 1'b0; il_in = 1'b1; ps_in = 2'b01; imem_rdata_in = 16'hBEEF;
    addr_hold = imem_addr_out;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("wait_stall", 32'(stall_out), 32'h1);
      check("wait_req", 32'(imem_req_out), 32'h1);
      check("wait_addr", 32'(imem_addr_out), 32'(addr_hold));
      il_in = 1'b0; ps_in = 2'b11; ra_in = 16'h5555;
    end
    imem_ready_in = 1'b1; ps_in = 2'b00;
    tick();
    check("wait_done_stall", 32'(stall_out), 32'h0);
    check("wait_done_ins", 32'(ins_out), 32'hBEEF);
    check("wait_done_pc", 32'(pc_out), 32'h1235);

    // Reset in the 2nd wait cycle
    imem_ready_in = 1'b0; il_in = 1'b1; ps_in = 2'b01; imem_rdata_in = 16'hDEAD;
    tick();
    il_in = 1'b0; ps_in = 2'b00;
    tick();
    check("rw_stall_pre", 32'(stall_out), 32'h1);
    rst = 1'b1;
    tick();
    check("rw_stall", 32'(stall_out), 32'h0);
    check("rw_pc", 32'(pc_out), 32'h0);
    check("rw_ins", 32'(ins_out), 32'h0);
    rst = 1'b0; imem_ready_in = 1'b1;
    tick(); tick();
    check("rw_noload_ins", 32'(ins_out), 32'h0);
    check("rw_noload_pc", 32'(pc_out), 32'h0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Fetch-side neighbour of the control unit `cu` in mycpu.
- Holds the program counter (PC) and the instruction register (IR), and drives the instruction memory address.
- Presents the latched instruction to `cu` on ins_out, which connects to `cu.ins_in`.
- Updates PC from `cu`'s ps_out and loads IR on `cu`'s il_out. A ready handshake with instruction memory stalls the fetch when memory is slow.

Parameters:
- ADDR_W, 16, PC and instruction memory address width.
- INS_W, 16, instruction width; fixed to match `cu.ins_in`.
- RESET_PC, 0, PC value after reset.
- NOP_INS, 16'h0000, IR value after reset and after a flush.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- il_in  in  1  instruction load request, from `cu.il_out`.
- ps_in  in  2  PC select, from `cu.ps_out`: 00 hold, 01 increment, 10 branch, 11 jump.
- ra_in  in  ADDR_W  register A value, used as the jump target.
- imem_rdata_in  in  INS_W  instruction memory read data.
- imem_ready_in  in  1  memory data valid for the current imem_addr_out.
- imem_addr_out  out  ADDR_W  fetch address; always equal to PC.
- imem_req_out  out  1  fetch request; high while a load is pending.
- ins_out  out  INS_W  IR contents, to `cu.ins_in`.
- pc_out  out  ADDR_W  current PC, for debug and the datapath.
- stall_out  out  1  high while waiting on memory; `cu` and the datapath hold state while it is high.

Behaviour:
- Reset (rst=1 at a clk edge) sets PC=RESET_PC, IR=NOP_INS, state=IDLE, stall_out=0, imem_req_out=0. Reset overrides all other inputs, including mid-stall.
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- FSM states are IDLE and WAIT.
- IDLE, il_in=1, imem_ready_in=1:
  - IR <= imem_rdata_in at the edge.
  - PC updates per ps_in at the same edge.
  - Remain in IDLE.
  - Zero-wait load: IR is visible the cycle after il_in.
- IDLE, il_in=1, imem_ready_in=0:
  - Go to WAIT.
  - PC and IR unchanged.
  - Latch ps_in and ra_in into pending registers.
- IDLE, il_in=0:
  - IR unchanged.
  - PC updates per ps_in, no memory access.
- WAIT:
  - stall_out=1 and imem_req_out=1 combinationally.
  - Inputs il_in, ps_in and ra_in are ignored.
  - When imem_ready_in=1: IR <= imem_rdata_in, PC updates per the latched pending ps/ra, return to IDLE.
- imem_req_out = il_in in IDLE, 1 in WAIT.
- imem_addr_out is always the current PC. It never changes while the FSM is in WAIT.
- PC update rules (computed from the current PC and IR at the update edge):
  - 00: PC unchanged.
  - 01: PC + 1.
  - 10: PC + sign-extend({IR[8:6], IR[2:0]}), a 6-bit two's-complement offset, range −32..+31.
  - 11: PC = ra_in (or the latched ra in WAIT).
  - All arithmetic is modulo 2^ADDR_W; wrap-around is silent (FFFF+1 -> 0000; 0000 + (−1) -> FFFF).
- Branch offset source: the offset is taken from the IR value before the load at that edge, i.e. the instruction currently being executed. This holds even when il_in=1 at the same edge.
- ins_out and pc_out are registered outputs with no combinational path from inputs.

Test Plan:
- Reset, then no activity:
  - Release rst, hold il_in=0 and ps_in=00 for 3 cycles -> pc_out=0000, ins_out=0000, stall_out=0, imem_req_out=0.
- Sequential zero-wait fetch:
  - Memory ready always; il_in=1 and ps_in=01 for 3 cycles; memory returns A001, A002, A003 -> ins_out follows one cycle later; pc_out 0001, 0002, 0003; imem_addr_out 0000, 0001, 0002 on the load cycles.
- Branch with negative offset and wrap:
  - IR=0x01C7 ({IR[8:6], IR[2:0]}=111111, i.e. −1), PC=0000, ps_in=10 -> PC=FFFF.
  - IR with offset +31 at PC=FFF0 -> PC=000F.
- Jump:
  - ra_in=1234, ps_in=11, il_in=0 -> pc_out=1234 next cycle; ins_out unchanged.
- Memory wait states:
  - il_in=1, ps_in=01, ready low for 3 cycles then high with data BEEF -> stall_out=1 for 3 cycles.
  - imem_addr_out stable throughout.
  - ps_in toggled to 11 during the wait is ignored.
  - After ready: ins_out=BEEF and PC = old PC + 1.
- Reset mid-wait:
  - Assert rst in the 2nd WAIT cycle -> next cycle state=IDLE, stall_out=0, PC=0000, IR=0000.
  - A later ready pulse does not load IR.
